// File: rtl/decim_pkg.sv
// +--------------------------------------------------------------------------+
// | decim_pkg : shared defaults and helpers for the boxcar decimator         |
// | Rev 1.0   : initial release                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

package decim_pkg;

  localparam int unsigned DW_DEFAULT       = 14;
  localparam int unsigned MAX_LOG2_DEFAULT = 7;

  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned max_log2);
    return dw + max_log2;
  endfunction

  function automatic logic [2:0] clamp_log2(input logic [2:0] req, input int unsigned max_log2);
    if (32'(req) > max_log2) begin
      return 3'(max_log2);
    end
    return req;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decim_chan.sv
// +--------------------------------------------------------------------------+
// | decim_chan : one lane of the decimator - accumulator, shifter and the    |
// |              optional round-half-up adder (enabled by DECIM_ROUND_EN)    |
// | Rev 1.0    : initial release                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module decim_chan
  import decim_pkg::*;
#(
  parameter int unsigned DW       = DW_DEFAULT,
  parameter int unsigned MAX_LOG2 = MAX_LOG2_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] din_i,
  input  logic          keep_acc_i,
  input  logic          add_i,
  input  logic          clr_i,
  input  logic          emit_i,
  input  logic [2:0]    shift_i,
  output logic [DW-1:0] dout_o
);

  localparam int unsigned AW = acc_width(DW, MAX_LOG2);

  logic [AW-1:0] acc_q, acc_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [AW-1:0] w_sum;
  logic [AW-1:0] w_rnd;
  logic [AW-1:0] w_rsum;

  always_comb begin
    w_sum = (keep_acc_i ? acc_q : '0) + AW'(din_i);
`ifdef DECIM_ROUND_EN
    w_rnd = (shift_i == 3'd0) ? '0 : (AW'(1) << (shift_i - 3'd1));
`else
    w_rnd = '0;
`endif
    // Rounded sum stays below 2^(DW+shift), so the shifted value always fits DW bits.
    w_rsum = w_sum + w_rnd;
    dout_d = emit_i ? DW'(w_rsum >> shift_i) : dout_q;

    acc_d = acc_q;
    if (emit_i) begin
      acc_d = '0;
    end else if (add_i) begin
      acc_d = w_sum;
    end else if (clr_i) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      dout_q <= '0;
    end else begin
      acc_q  <= acc_d;
      dout_q <= dout_d;
    end
  end

  assign dout_o = dout_q;

endmodule

`default_nettype wire

// File: rtl/decim_avg_multi.sv
// +--------------------------------------------------------------------------+
// | decim_avg_multi : multi-channel 2^N boxcar-averaging decimator with sync |
// |                   realignment; DECIM_ROUND_EN selects round-half-up      |
// | Rev 1.0         : initial release                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module decim_avg_multi
  import decim_pkg::*;
#(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned DW       = DW_DEFAULT,
  parameter int unsigned MAX_LOG2 = MAX_LOG2_DEFAULT
) (
  input  logic                   I_clk,
  input  logic                   I_rst,
  input  logic [CHANNELS*DW-1:0] I_din,
  input  logic                   I_valid,
  input  logic [2:0]             I_log2_ratio,
  input  logic                   I_sync,
  output logic [CHANNELS*DW-1:0] O_dout,
  output logic                   O_rdy
);

  logic [MAX_LOG2-1:0] cnt_q, cnt_d;
  logic [2:0]          nact_q, nact_d;
  logic                rdy_q, rdy_d;

  logic [2:0]          w_n_new;
  logic [MAX_LOG2-1:0] w_last_cnt;
  logic                w_keep_acc;
  logic                w_add;
  logic                w_clr;
  logic                w_emit;
  logic [2:0]          w_shift;

  assign w_n_new    = clamp_log2(I_log2_ratio, MAX_LOG2);
  assign w_last_cnt = ~({MAX_LOG2{1'b1}} << nact_q);

  always_comb begin
    w_keep_acc = 1'b1;
    w_add      = 1'b0;
    w_clr      = 1'b0;
    w_emit     = 1'b0;
    w_shift    = nact_q;
    cnt_d      = cnt_q;
    nact_d     = nact_q;

    if (I_sync) begin
      // Partial frame is dropped; a coincident sample opens the new frame,
      // or forms a frame by itself when the new exponent is zero.
      w_keep_acc = 1'b0;
      w_clr      = 1'b1;
      w_shift    = 3'd0;
      nact_d     = w_n_new;
      w_emit     = I_valid && (w_n_new == 3'd0);
      w_add      = I_valid && (w_n_new != 3'd0);
      cnt_d      = w_add ? MAX_LOG2'(1) : '0;
    end else if (I_valid) begin
      if (cnt_q == w_last_cnt) begin
        w_emit = 1'b1;
        cnt_d  = '0;
        nact_d = w_n_new;
      end else begin
        w_add = 1'b1;
        cnt_d = cnt_q + MAX_LOG2'(1);
      end
    end

    rdy_d = w_emit;
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      cnt_q  <= '0;
      nact_q <= w_n_new;
      rdy_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      nact_q <= nact_d;
      rdy_q  <= rdy_d;
    end
  end

  assign O_rdy = rdy_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    decim_chan #(
      .DW       (DW),
      .MAX_LOG2 (MAX_LOG2)
    ) u_chan (
      .clk_i      (I_clk),
      .rst_i      (I_rst),
      .din_i      (I_din[k*DW +: DW]),
      .keep_acc_i (w_keep_acc),
      .add_i      (w_add),
      .clr_i      (w_clr),
      .emit_i     (w_emit),
      .shift_i    (w_shift),
      .dout_o     (O_dout[k*DW +: DW])
    );
  end

endmodule

`default_nettype wire
